// File: rtl/gpu_seg_pkg.sv
// +-----------------------------------------------------------------------+
// | gpu_seg_pkg : shared defaults, FSM state type and edge-mask helper   |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
`default_nettype none

package gpu_seg_pkg;

   localparam int DEF_SEG_PIX = 16;
   localparam int DEF_X_W     = 10;
   localparam int DEF_Y_W     = 9;
   localparam int SEG_PIX_MAX = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2
   } seg_state_t;

   // Built at the widest legal segment; callers keep the low SEG_PIX bits.
   // Right edge: pixels below pos; pos==0 means the row ends on a boundary.
   function automatic logic [SEG_PIX_MAX-1:0] seg_edge_mask(input logic [5:0] pos,
                                                            input logic       is_right);
      logic [SEG_PIX_MAX-1:0] ones;
      ones = '1;
      if (is_right)
         return (pos == 6'd0) ? ones : ~(ones << pos);
      return ones << pos;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gpu_seg_edge_mask.sv
// +-----------------------------------------------------------------------+
// | gpu_seg_edge_mask : combinational left/right segment edge mask       |
// | Revision          : 1.0  initial release                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module gpu_seg_edge_mask
   import gpu_seg_pkg::*;
#(
   parameter int SEG_PIX = DEF_SEG_PIX,
   parameter int SEG_W   = $clog2(SEG_PIX)
)(
   input  logic [SEG_W-1:0]   pos,
   input  logic               is_right,
   output logic [SEG_PIX-1:0] mask
);

   assign mask = SEG_PIX'(seg_edge_mask(6'(pos), is_right));

endmodule

`default_nettype wire

// File: rtl/gpu_seg_mask_gen.sv
// +-----------------------------------------------------------------------+
// | gpu_seg_mask_gen : walks a VRAM rectangle as aligned segment beats   |
// | Revision         : 1.0  initial release                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module gpu_seg_mask_gen
   import gpu_seg_pkg::*;
#(
   parameter int SEG_PIX = DEF_SEG_PIX,
   parameter int X_W     = DEF_X_W,
   parameter int Y_W     = DEF_Y_W,
   parameter int SEG_W   = $clog2(SEG_PIX)
)(
   input  logic                 clk,
   input  logic                 i_nrst,
   input  logic                 i_start,
   input  logic [X_W-1:0]       i_x0,
   input  logic [Y_W-1:0]       i_y0,
   input  logic [X_W:0]         i_w,
   input  logic [Y_W:0]         i_h,
   input  logic                 i_abort,
   output logic                 o_busy,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [X_W-SEG_W-1:0] o_segX,
   output logic [Y_W-1:0]       o_y,
   output logic [SEG_PIX-1:0]   o_mask,
   output logic                 o_firstSeg,
   output logic                 o_lastSeg,
   output logic                 o_lastAll,
   output logic                 o_done
);

   localparam int SX_W = X_W - SEG_W;
   localparam int NS_W = SX_W + 2;

   seg_state_t r_state, w_state_nxt;

   logic [X_W-1:0]     r_x0;
   logic [Y_W-1:0]     r_y0;
   logic [X_W:0]       r_w;
   logic [Y_W:0]       r_h;
   logic [NS_W-1:0]    r_seg_cnt;
   logic [Y_W:0]       r_row_cnt;

   logic               r_valid;
   logic [SX_W-1:0]    r_segx;
   logic [Y_W-1:0]     r_y;
   logic [SEG_PIX-1:0] r_mask;
   logic               r_first;
   logic               r_last;
   logic               r_last_all;
   logic               r_done;

   logic [SEG_W-1:0]   w_left_pos;
   logic [SEG_W-1:0]   w_right_pos;
   logic [X_W+1:0]     w_span;
   logic [NS_W-1:0]    w_n_seg;
   logic [SEG_PIX-1:0] w_mask_left;
   logic [SEG_PIX-1:0] w_mask_right;
   logic               w_empty;
   logic               w_consume;

   logic               w_load_beat;
   logic               w_adv_beat;
   logic               w_finish;

   logic [NS_W-1:0]    w_k_nxt;
   logic [Y_W:0]       w_r_nxt;
   logic               w_first_nxt;
   logic               w_last_nxt;
   logic               w_last_all_nxt;
   logic [SX_W-1:0]    w_segx_nxt;
   logic [Y_W-1:0]     w_y_nxt;
   logic [SEG_PIX-1:0] w_mask_nxt;

   // Low SEG_W bits of a sum depend only on the low bits of the operands,
   // so this equals (X0+W) at full width truncated to SEG_W.
   assign w_left_pos  = r_x0[SEG_W-1:0];
   assign w_right_pos = r_x0[SEG_W-1:0] + r_w[SEG_W-1:0];
   assign w_span      = (X_W+2)'(w_left_pos) + (X_W+2)'(r_w) + (X_W+2)'(SEG_PIX-1);
   assign w_n_seg     = NS_W'(w_span >> SEG_W);
   assign w_empty     = (r_w == '0) || (r_h == '0);
   assign w_consume   = r_valid & i_ready;

   gpu_seg_edge_mask #(.SEG_PIX(SEG_PIX), .SEG_W(SEG_W)) u_left_mask (
      .pos      (w_left_pos),
      .is_right (1'b0),
      .mask     (w_mask_left)
   );

   gpu_seg_edge_mask #(.SEG_PIX(SEG_PIX), .SEG_W(SEG_W)) u_right_mask (
      .pos      (w_right_pos),
      .is_right (1'b1),
      .mask     (w_mask_right)
   );

   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_beat = 1'b0;
      w_adv_beat  = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            if (i_abort || w_empty) begin
               w_state_nxt = ST_IDLE;
               w_finish    = 1'b1;
            end else begin
               w_state_nxt = ST_EMIT;
               w_load_beat = 1'b1;
            end
         end
         ST_EMIT: begin
            if (i_abort || (w_consume && r_last_all)) begin
               w_state_nxt = ST_IDLE;
               w_finish    = 1'b1;
            end else if (w_consume) begin
               w_adv_beat = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Next beat position: (0,0) on load, otherwise step along the row.
   always_comb begin
      w_k_nxt = '0;
      w_r_nxt = '0;
      if (w_adv_beat) begin
         if (r_last) begin
            w_r_nxt = r_row_cnt + (Y_W+1)'(1);
         end else begin
            w_k_nxt = r_seg_cnt + NS_W'(1);
            w_r_nxt = r_row_cnt;
         end
      end
      w_first_nxt    = (w_k_nxt == '0);
      w_last_nxt     = (w_k_nxt == w_n_seg - NS_W'(1));
      w_last_all_nxt = w_last_nxt && (w_r_nxt == r_h - (Y_W+1)'(1));
      w_segx_nxt     = r_x0[X_W-1:SEG_W] + w_k_nxt[SX_W-1:0];
      w_y_nxt        = r_y0 + w_r_nxt[Y_W-1:0];
      w_mask_nxt     = (w_first_nxt ? w_mask_left : '1) & (w_last_nxt ? w_mask_right : '1);
   end

   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_x0       <= '0;
         r_y0       <= '0;
         r_w        <= '0;
         r_h        <= '0;
         r_seg_cnt  <= '0;
         r_row_cnt  <= '0;
         r_valid    <= 1'b0;
         r_segx     <= '0;
         r_y        <= '0;
         r_mask     <= '0;
         r_first    <= 1'b0;
         r_last     <= 1'b0;
         r_last_all <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (r_state == ST_IDLE && i_start) begin
            r_x0 <= i_x0;
            r_y0 <= i_y0;
            r_w  <= i_w;
            r_h  <= i_h;
         end
         if (w_finish) begin
            r_valid <= 1'b0;
         end else if (w_load_beat || w_adv_beat) begin
            r_valid    <= 1'b1;
            r_seg_cnt  <= w_k_nxt;
            r_row_cnt  <= w_r_nxt;
            r_segx     <= w_segx_nxt;
            r_y        <= w_y_nxt;
            r_mask     <= w_mask_nxt;
            r_first    <= w_first_nxt;
            r_last     <= w_last_nxt;
            r_last_all <= w_last_all_nxt;
         end
      end
   end

   assign o_busy     = (r_state != ST_IDLE);
   assign o_valid    = r_valid;
   assign o_segX     = r_segx;
   assign o_y        = r_y;
   assign o_mask     = r_mask;
   assign o_firstSeg = r_first;
   assign o_lastSeg  = r_last;
   assign o_lastAll  = r_last_all;
   assign o_done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_gpu_seg_mask_gen.sv
// +-----------------------------------------------------------------------+
// | tb_gpu_seg_mask_gen : directed self-checking bench, 16-pixel segments |
// | Revision            : 1.0  initial release                            |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_gpu_seg_mask_gen;

   logic        clk;
   logic        i_nrst;
   logic        i_start;
   logic [9:0]  i_x0;
   logic [8:0]  i_y0;
   logic [10:0] i_w;
   logic [9:0]  i_h;
   logic        i_abort;
   logic        o_busy;
   logic        o_valid;
   logic        i_ready;
   logic [5:0]  o_segX;
   logic [8:0]  o_y;
   logic [15:0] o_mask;
   logic        o_firstSeg;
   logic        o_lastSeg;
   logic        o_lastAll;
   logic        o_done;

   gpu_seg_mask_gen #(.SEG_PIX(16), .X_W(10), .Y_W(9)) dut (
      .clk        (clk),
      .i_nrst     (i_nrst),
      .i_start    (i_start),
      .i_x0       (i_x0),
      .i_y0       (i_y0),
      .i_w        (i_w),
      .i_h        (i_h),
      .i_abort    (i_abort),
      .o_busy     (o_busy),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_segX     (o_segX),
      .o_y        (o_y),
      .o_mask     (o_mask),
      .o_firstSeg (o_firstSeg),
      .o_lastSeg  (o_lastSeg),
      .o_lastAll  (o_lastAll),
      .o_done     (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // beat = {segX, y, mask, first, last, lastAll}
   typedef logic [33:0] beat_t;

   int    n_total = 0;
   int    n_bad   = 0;
   beat_t beats[$];
   int    first_valid_cyc;
   int    last_accept_cyc;
   int    done_cyc;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic beat_t mk(input int segx, input int y, input int mask,
                                input bit f, input bit l, input bit a);
      return {6'(segx), 9'(y), 16'(mask), f, l, a};
   endfunction

   task automatic chk_beat(input string tag, input int idx, input beat_t exp);
      beat_t act;
      act = (idx < beats.size()) ? beats[idx] : '0;
      chk(tag, 64'(act), 64'(exp));
   endtask

   task automatic start_cmd(input int x0, input int y0, input int w, input int h);
      @(negedge clk);
      i_x0    = 10'(x0);
      i_y0    = 9'(y0);
      i_w     = 11'(w);
      i_h     = 10'(h);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk("busy_after_start", 64'(o_busy), 64'd1);
   endtask

   // Consumes beats until o_done; optionally stalls stall_n cycles on one beat.
   task automatic collect(input int stall_beat, input int stall_n);
      int    cyc;
      int    stalls;
      bit    fin;
      beat_t cur;
      beat_t held;
      cyc = 0; stalls = 0; fin = 1'b0; held = '0;
      first_valid_cyc = -1; last_accept_cyc = -1; done_cyc = -1;
      beats.delete();
      while (!fin && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (o_done) begin
            fin = 1'b1;
            done_cyc = cyc;
            chk("busy_at_done", 64'(o_busy), 64'd0);
         end else if (o_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            cur = {o_segX, o_y, o_mask, o_firstSeg, o_lastSeg, o_lastAll};
            if (beats.size() == stall_beat && stalls < stall_n) begin
               if (stalls > 0) chk("bp_hold", 64'(cur), 64'(held));
               held    = cur;
               stalls++;
               i_ready = 1'b0;
            end else begin
               i_ready = 1'b1;
               beats.push_back(cur);
               last_accept_cyc = cyc;
            end
         end
      end
      i_ready = 1'b1;
      chk("done_seen", 64'(fin), 64'd1);
   endtask

   initial begin
      i_nrst = 1'b0; i_start = 1'b0; i_x0 = '0; i_y0 = '0;
      i_w = '0; i_h = '0; i_abort = 1'b0; i_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy",  64'(o_busy),  64'd0);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_done",  64'(o_done),  64'd0);
      chk("rst_beat",  64'({o_segX, o_y, o_mask, o_firstSeg, o_lastSeg, o_lastAll}), 64'd0);
      i_nrst = 1'b1;

      // single segment
      start_cmd(3, 0, 10, 1);
      collect(-1, 0);
      chk("single_n", 64'(beats.size()), 64'd1);
      chk_beat("single_b0", 0, mk(0, 0, 'h1FF8, 1, 1, 1));
      chk("single_lat", 64'(first_valid_cyc), 64'd1);
      chk("single_done_gap", 64'(done_cyc - last_accept_cyc), 64'd1);

      // three segments
      start_cmd(14, 0, 20, 1);
      collect(-1, 0);
      chk("three_n", 64'(beats.size()), 64'd3);
      chk("three_lat", 64'(first_valid_cyc), 64'd1);
      chk_beat("three_b0", 0, mk(0, 0, 'hC000, 1, 0, 0));
      chk_beat("three_b1", 1, mk(1, 0, 'hFFFF, 0, 0, 0));
      chk_beat("three_b2", 2, mk(2, 0, 'h0003, 0, 1, 1));

      // aligned
      start_cmd(16, 0, 16, 1);
      collect(-1, 0);
      chk("aligned_n", 64'(beats.size()), 64'd1);
      chk_beat("aligned_b0", 0, mk(1, 0, 'hFFFF, 1, 1, 1));

      // X and Y wrap-around, two rows
      start_cmd(1020, 511, 8, 2);
      collect(-1, 0);
      chk("wrap_n", 64'(beats.size()), 64'd4);
      chk_beat("wrap_b0", 0, mk(63, 511, 'hF000, 1, 0, 0));
      chk_beat("wrap_b1", 1, mk(0,  511, 'h000F, 0, 1, 0));
      chk_beat("wrap_b2", 2, mk(63, 0,   'hF000, 1, 0, 0));
      chk_beat("wrap_b3", 3, mk(0,  0,   'h000F, 0, 1, 1));

      // backpressure on the second beat
      start_cmd(0, 7, 48, 1);
      collect(1, 3);
      chk("bp_n", 64'(beats.size()), 64'd3);
      chk_beat("bp_b0", 0, mk(0, 7, 'hFFFF, 1, 0, 0));
      chk_beat("bp_b1", 1, mk(1, 7, 'hFFFF, 0, 0, 0));
      chk_beat("bp_b2", 2, mk(2, 7, 'hFFFF, 0, 1, 1));

      // zero width: no beats, done the cycle after LOAD
      start_cmd(0, 0, 0, 1);
      collect(-1, 0);
      chk("empty_n", 64'(beats.size()), 64'd0);
      chk("empty_done_cyc", 64'(done_cyc), 64'd1);

      // full VRAM width, unaligned start
      start_cmd(5, 0, 1024, 1);
      collect(-1, 0);
      chk("full_n", 64'(beats.size()), 64'd65);
      chk_beat("full_first", 0,  mk(0, 0, 'hFFE0, 1, 0, 0));
      chk_beat("full_b1",    1,  mk(1, 0, 'hFFFF, 0, 0, 0));
      chk_beat("full_b63",   63, mk(63, 0, 'hFFFF, 0, 0, 0));
      chk_beat("full_last",  64, mk(0, 0, 'h001F, 0, 1, 1));

      // abort during the second beat
      start_cmd(0, 0, 64, 4);
      @(negedge clk);
      chk("abort_b0_segx", 64'(o_segX), 64'd0);
      @(negedge clk);
      chk("abort_b1_segx", 64'(o_segX), 64'd1);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      chk("abort_valid", 64'(o_valid), 64'd0);
      chk("abort_done",  64'(o_done),  64'd1);
      chk("abort_busy",  64'(o_busy),  64'd0);
      @(negedge clk);
      chk("abort_done_pulse", 64'(o_done), 64'd0);

      // abort while idle does nothing
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      chk("idle_abort_done", 64'(o_done), 64'd0);
      chk("idle_abort_busy", 64'(o_busy), 64'd0);

      // new command after the abort
      start_cmd(32, 3, 16, 1);
      collect(-1, 0);
      chk("post_abort_n", 64'(beats.size()), 64'd1);
      chk_beat("post_abort_b0", 0, mk(2, 3, 'hFFFF, 1, 1, 1));

      // asynchronous reset mid-command
      start_cmd(0, 0, 64, 4);
      repeat (2) @(negedge clk);
      i_nrst = 1'b0;
      #1;
      chk("arst_valid", 64'(o_valid), 64'd0);
      chk("arst_busy",  64'(o_busy),  64'd0);
      chk("arst_done",  64'(o_done),  64'd0);
      chk("arst_beat",  64'({o_segX, o_y, o_mask, o_firstSeg, o_lastSeg, o_lastAll}), 64'd0);
      @(negedge clk);
      i_nrst = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
